// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Data-memory bus controller for the d16 core. Turns a load/store
//             request from the control FSM (MEM state) into one handshaked
//             bus transaction, steers byte lanes, zero-extends byte loads,
//             and stalls the control unit via mem_wait until completion.
//             Provides a bus timeout (sticky bus_err) and misaligned word
//             detection (sticky align_err).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  rising-edge clock
//    rst        in   1  synchronous active-high reset
//    en         in   1  global clock enable, all registers hold when low
//    mem_en     in   1  access request (level)
//    mem_we     in   1  1 = store, 0 = load
//    mem_byte   in   1  1 = byte access, 0 = word access
//    mem_addr   in  16  byte address
//    mem_wdata  in  16  store data (byte stores use [7:0])
//    mem_rdata  out 16  registered load result
//    mem_wait   out  1  combinational stall to the control unit
//    bus_err    out  1  sticky timeout flag
//    align_err  out  1  sticky misaligned-word flag
//    bus_req    out  1  bus request strobe
//    bus_we     out  1  bus write enable
//    bus_be     out  2  byte enables (bit0 = low byte, bit1 = high byte)
//    bus_addr   out 15  word address
//    bus_wdata  out 16  bus write data
//    bus_rdata  in  16  bus read data, valid with bus_ack
//    bus_ack    in   1  single-cycle completion strobe
// ============================================================================
module mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic        mem_byte,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_wait,
    output logic        bus_err,
    output logic        align_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_be,
    output logic [14:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    // Last counter value before an unanswered request is abandoned.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched request
    logic        r_we;
    logic        r_byte;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic [7:0]  r_cnt;
    logic        r_bus_err;
    logic        r_align_err;
    logic [15:0] r_rdata;

    // Decoded actions for the register process
    logic        w_capture;
    logic        w_cnt_inc;
    logic        w_ack_take;
    logic        w_abort_take;
    logic        w_align_set;

    logic        w_misaligned;
    logic        w_in_req;
    logic        w_cnt_last;
    logic [15:0] w_load_data;
    logic [7:0]  w_load_byte;

    assign w_misaligned = ~mem_byte & mem_addr[0];
    assign w_in_req     = (r_state == S_REQ);
    assign w_cnt_last   = (r_cnt == c_CNT_LAST);

    // Byte loads pick the lane addressed by bit 0 and zero-extend.
    assign w_load_byte  = r_addr[0] ? bus_rdata[15:8] : bus_rdata[7:0];
    assign w_load_data  = r_byte ? {8'h00, w_load_byte} : bus_rdata;

    // ------------------------------------------------------------------
    // Next-state, action decode and mem_wait
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_ack_take   = 1'b0;
        w_abort_take = 1'b0;
        w_align_set  = 1'b0;
        mem_wait     = 1'b0;

        case (r_state)
            S_IDLE: begin
                mem_wait = mem_en;
                if (mem_en) begin
                    w_capture = 1'b1;
                    if (w_misaligned) begin
                        // No bus cycle; report and complete immediately.
                        w_align_set = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle wins over the abort.
                mem_wait = ~(bus_ack | w_cnt_last);
                if (bus_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_cnt_last) begin
                    w_abort_take = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                // Stay here while the request is held so it is never reissued.
                if (!mem_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (rst) begin
            mem_wait = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_cnt       <= 8'h00;
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
            r_rdata     <= 16'h0000;
        end else if (en) begin
            r_state <= w_state_nxt;

            if (w_capture) begin
                r_we    <= mem_we;
                r_byte  <= mem_byte;
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_cnt   <= 8'h00;
            end

            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_align_set) begin
                r_align_err <= 1'b1;
                r_rdata     <= 16'h0000;
            end

            // Stores leave the previous load result untouched.
            if (w_ack_take && !r_we) begin
                r_rdata <= w_load_data;
            end

            if (w_abort_take) begin
                r_bus_err <= 1'b1;
                r_rdata   <= 16'h0000;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs: driven from the latched request only while in REQ, so
    // they are all zero outside a transaction and drop with the state.
    // ------------------------------------------------------------------
    always_comb begin
        bus_req   = w_in_req;
        bus_we    = 1'b0;
        bus_be    = 2'b00;
        bus_addr  = 15'h0000;
        bus_wdata = 16'h0000;
        if (w_in_req) begin
            bus_we   = r_we;
            bus_addr = r_addr[15:1];
            if (r_we && r_byte) begin
                bus_be = r_addr[0] ? 2'b10 : 2'b01;
            end else begin
                bus_be = 2'b11;
            end
            // Byte data is replicated on both lanes; bus_be selects the lane.
            bus_wdata = r_byte ? {r_wdata[7:0], r_wdata[7:0]} : r_wdata;
        end
    end

    assign mem_rdata = r_rdata;
    assign bus_err   = r_bus_err;
    assign align_err = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench for mem_ctrl: directed vector table,
//             hand-written reset / clock-enable sequences, and randomized
//             accesses checked against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mem_en;
    logic        mem_we;
    logic        mem_byte;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_wait;
    logic        bus_err;
    logic        align_err;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_be;
    logic [14:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        exp_berr;
    logic        exp_aerr;
    logic [15:0] cur_rdata;

    mem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_wait  (mem_wait),
        .bus_err   (bus_err),
        .align_err (align_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          k;      // cycle of ack after request; 0 or >TMO = no ack
        logic [15:0] rd;
        logic [1:0]  be;
        logic [15:0] ewd;
        logic [15:0] erd;
        int          hold;   // extra DONE cycles with mem_en still high
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full request: IDLE -> (REQ)* -> DONE -> IDLE, checked every cycle.
    task automatic access(input logic we, input logic byt, input logic [15:0] addr,
                          input logic [15:0] wdata, input int k, input logic [15:0] rd,
                          input logic [1:0] ebe, input logic [15:0] ewd,
                          input logic [15:0] erd, input int hold);
        logic mis;
        logic tmo;
        int   e;
        mis = !byt && addr[0];
        tmo = !mis && (k < 1 || k > TMO);
        e   = mis ? 0 : (tmo ? TMO : k);

        @(posedge clk); #1;
        mem_en = 1'b1; mem_we = we; mem_byte = byt; mem_addr = addr;
        mem_wdata = wdata; bus_rdata = rd; bus_ack = 1'b0;
        @(negedge clk);
        chk("wait_issue", 32'(mem_wait), 32'd1);
        chk("req_issue", 32'(bus_req), 32'd0);

        for (int c = 1; c <= e; c++) begin
            @(posedge clk); #1;
            // Request inputs must not be resampled during the transaction.
            mem_we = ~we; mem_byte = ~byt;
            mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
            bus_ack = (c == k);
            @(negedge clk);
            chk("req_on", 32'(bus_req), 32'd1);
            chk("bus_we", 32'(bus_we), 32'(we));
            chk("bus_addr", 32'(bus_addr), 32'(addr[15:1]));
            chk("bus_be", 32'(bus_be), 32'(ebe));
            if (we) chk("bus_wdata", 32'(bus_wdata), 32'(ewd));
            chk("wait_req", 32'(mem_wait), (c != e) ? 32'd1 : 32'd0);
        end

        @(posedge clk); #1;
        bus_ack = 1'b1;   // ignored in DONE
        exp_berr  = exp_berr | tmo;
        exp_aerr  = exp_aerr | mis;
        cur_rdata = erd;
        @(negedge clk);
        chk("req_off", 32'(bus_req), 32'd0);
        chk("wait_done", 32'(mem_wait), 32'd0);
        chk("rdata", 32'(mem_rdata), 32'(erd));
        chk("bus_err", 32'(bus_err), 32'(exp_berr));
        chk("align_err", 32'(align_err), 32'(exp_aerr));

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_req", 32'(bus_req), 32'd0);
            chk("hold_wait", 32'(mem_wait), 32'd0);
            chk("hold_rdata", 32'(mem_rdata), 32'(erd));
        end

        @(posedge clk); #1;
        mem_en = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        chk("wait_release", 32'(mem_wait), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_idle", 32'(mem_wait), 32'd0);
        chk("req_idle", 32'(bus_req), 32'd0);
    endtask

    // Transaction-level reference: lane rules and result selection.
    task automatic model(input logic we, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wdata, input int k, input logic [15:0] rd,
                         output logic [1:0] be, output logic [15:0] wd,
                         output logic [15:0] rdo);
        int lane_shift;
        lane_shift = addr[0] ? 8 : 0;
        if (we && byt) be = addr[0] ? 2'b10 : 2'b01;
        else           be = 2'b11;
        wd = byt ? ((wdata & 16'h00FF) * 16'h0101) : wdata;
        if ((!byt && addr[0]) || k < 1 || k > TMO) rdo = 16'h0000;
        else if (we)                               rdo = cur_rdata;
        else if (byt)                              rdo = (rd >> lane_shift) & 16'h00FF;
        else                                       rdo = rd;
    endtask

    initial begin
        logic        r_we_v, r_byt_v;
        logic [15:0] r_addr_v, r_wd_v, r_rd_v, m_wd, m_rd;
        logic [1:0]  m_be;
        int          r_k;

        //                 we    byt   addr      wdata     k   rd        be     ewd       erd       hold
        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h5555, 3,  16'hBEEF, 2'b11, 16'h5555, 16'hBEEF, 0};
        tbl[1] = '{1'b1, 1'b1, 16'h0021, 16'h12A5, 1,  16'h0000, 2'b10, 16'hA5A5, 16'hBEEF, 0};
        tbl[2] = '{1'b0, 1'b1, 16'h0021, 16'h0000, 2,  16'h7F00, 2'b11, 16'h0000, 16'h007F, 0};
        tbl[3] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 0,  16'h1111, 2'b11, 16'h0000, 16'h0000, 0};
        tbl[4] = '{1'b0, 1'b0, 16'h0032, 16'h0000, 4,  16'hCAFE, 2'b11, 16'h0000, 16'hCAFE, 0};
        tbl[5] = '{1'b1, 1'b0, 16'h0003, 16'h9999, 1,  16'h0000, 2'b11, 16'h9999, 16'h0000, 0};
        tbl[6] = '{1'b1, 1'b1, 16'h0020, 16'h00C3, 2,  16'h0000, 2'b01, 16'hC3C3, 16'h0000, 0};
        tbl[7] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 1,  16'h7F9C, 2'b11, 16'h0000, 16'h009C, 5};
        tbl[8] = '{1'b1, 1'b0, 16'h0100, 16'h1234, 2,  16'hFFFF, 2'b11, 16'h1234, 16'h009C, 0};

        rst = 1'b1; en = 1'b1; mem_en = 1'b1; mem_we = 1'b0; mem_byte = 1'b0;
        mem_addr = 16'h0000; mem_wdata = 16'h0000; bus_rdata = 16'h0000; bus_ack = 1'b0;
        exp_berr = 1'b0; exp_aerr = 1'b0; cur_rdata = 16'h0000;

        // Reset state (mem_en high to show mem_wait is forced low)
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wait", 32'(mem_wait), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_wdata", 32'(bus_wdata), 32'd0);
        chk("rst_rdata", 32'(mem_rdata), 32'd0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        chk("rst_aerr", 32'(align_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_en = 1'b0;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            access(tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata, tbl[i].k,
                   tbl[i].rd, tbl[i].be, tbl[i].ewd, tbl[i].erd, tbl[i].hold);
        end

        // Reset while in REQ
        @(posedge clk); #1;
        mem_en = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 16'h0050; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstreq_pre", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; mem_en = 1'b0;
        @(negedge clk);
        chk("rstreq_wait", 32'(mem_wait), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_req", 32'(bus_req), 32'd0);
        chk("rstreq_berr", 32'(bus_err), 32'd0);
        chk("rstreq_aerr", 32'(align_err), 32'd0);
        chk("rstreq_rdata", 32'(mem_rdata), 32'd0);
        exp_berr = 1'b0; exp_aerr = 1'b0; cur_rdata = 16'h0000;

        // Clock enable low for 3 cycles during REQ
        @(posedge clk); #1;
        mem_en = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 16'h0044;
        bus_rdata = 16'h5A3C; bus_ack = 1'b0;
        @(negedge clk);
        chk("en_wait_n", 32'(mem_wait), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("en_req_c1", 32'(bus_req), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk); #1;
            en = 1'b0;
            @(negedge clk);
            chk("en_hold_req", 32'(bus_req), 32'd1);
            chk("en_hold_addr", 32'(bus_addr), 32'h0022);
            chk("en_hold_be", 32'(bus_be), 32'd3);
            chk("en_hold_wait", 32'(mem_wait), 32'd1);
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("en_resume_wait", 32'(mem_wait), 32'd1);
        @(posedge clk); #1;
        bus_ack = 1'b1;
        @(negedge clk);
        chk("en_ack_wait", 32'(mem_wait), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        chk("en_done_req", 32'(bus_req), 32'd0);
        chk("en_done_rdata", 32'(mem_rdata), 32'h5A3C);
        chk("en_done_berr", 32'(bus_err), 32'd0);
        cur_rdata = 16'h5A3C;
        @(posedge clk); #1;

        // Randomized accesses against the reference model
        for (int n = 0; n < 40; n++) begin
            r_we_v   = 1'($urandom_range(0, 1));
            r_byt_v  = 1'($urandom_range(0, 1));
            r_addr_v = 16'($urandom);
            r_wd_v   = 16'($urandom);
            r_rd_v   = 16'($urandom);
            r_k      = int'($urandom_range(0, TMO + 2));
            model(r_we_v, r_byt_v, r_addr_v, r_wd_v, r_k, r_rd_v, m_be, m_wd, m_rd);
            access(r_we_v, r_byt_v, r_addr_v, r_wd_v, r_k, r_rd_v, m_be, m_wd, m_rd,
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Data-memory bus controller for the d16 core. It sits between the control FSM and the external RAM bus. While the control unit is in its MEM state, the block turns the load/store request into one handshaked bus transaction, performs byte-lane steering and extension, and drives `mem_wait` back to the control unit until the access completes. It also supplies a bus timeout and reports misaligned accesses.

## Interface
- `TIMEOUT`, default 16: maximum number of enabled REQ cycles without `bus_ack` before the access is aborted. Valid range is 2..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global clock enable. When low, all registers hold.
- `mem_en` in 1: access request, level-sensitive. Driven by control_o[`BIT_MEM`].
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_byte` in 1: 1 = byte access, 0 = word access.
- `mem_addr` in 16: byte address.
- `mem_wdata` in 16: store data. For byte stores, bits [7:0] are used.
- `mem_rdata` out 16: registered load result.
- `mem_wait` out 1: combinational. Feeds the control unit's `mem_wait` input.
- `bus_err` out 1: sticky timeout flag.
- `align_err` out 1: sticky misaligned-word flag.
- `bus_req` out 1: bus request strobe.
- `bus_we` out 1: bus write enable.
- `bus_be` out 2: byte enables; bit 0 = low byte, bit 1 = high byte.
- `bus_addr` out 15: word address, equal to mem_addr[15:1].
- `bus_wdata` out 16: bus write data.
- `bus_rdata` in 16: bus read data, valid in the cycle `bus_ack` is high.
- `bus_ack` in 1: single-cycle completion strobe from the bus.

## Operation
- **States:** IDLE, REQ, DONE. Reset state is IDLE.
- **Request capture in IDLE.** When `mem_en=1`, the block latches we, byte, addr and wdata into request registers.
  - Misaligned word access (`mem_byte=0` and mem_addr[0]=1): go to DONE, set `align_err`, load `mem_rdata`=0. No bus cycle is issued.
  - Otherwise go to REQ and clear the timeout counter.
- **REQ.** `bus_req`=1 and all bus outputs come from the latched registers.
  - `bus_ack`=1: capture the load data, go to DONE.
  - No ack and counter = TIMEOUT-1: abort. Set `bus_err`, load `mem_rdata`=0, go to DONE.
  - No ack otherwise: increment the counter.
- **DONE.** Hold `mem_rdata`. Stay in DONE while `mem_en`=1; return to IDLE when `mem_en`=0. A request held high never re-issues a bus cycle.
- **Byte lanes:**
  - Byte store: `bus_wdata`={wdata[7:0],wdata[7:0]}; `bus_be`=2'b10 when addr[0]=1, else 2'b01.
  - Word access: `bus_be`=2'b11 and `bus_wdata`=wdata.
  - Load, any width: `bus_be`=2'b11.
  - Byte load: `mem_rdata`={8'h00, selected byte}. addr[0]=1 selects bus_rdata[15:8]; addr[0]=0 selects [7:0]. Zero extension only.
  - Store: `mem_rdata` is left unchanged.
- **`mem_wait` equations:**
  - IDLE: `mem_wait` = `mem_en`.
  - REQ: `mem_wait` = ~(`bus_ack` | timeout-abort).
  - DONE: `mem_wait` = 0.
  - Forced to 0 while `rst`=1.
- **Ignored inputs:** `bus_ack` in IDLE and DONE. Request inputs are not re-sampled in REQ or DONE.
- **Clearing flags:** `bus_err` and `align_err` are cleared only by `rst`.
- **`en` low:** state, counter, flags and `mem_rdata` hold, and the bus outputs keep their values. `mem_wait` is still evaluated combinationally.

## Timing
- **Reset values:** state=IDLE, `mem_rdata`=0, `bus_err`=0, `align_err`=0, `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0, counter=0.
- **Reset mid-transaction:** `rst` in any state returns to IDLE on the next edge, and `bus_req` drops on that same edge.
- **Normal access:** `mem_en` rises in cycle N. `bus_req` is high from N+1. If the ack arrives at N+k (k≥1), `mem_wait` is low in N+k, `mem_rdata` is valid from N+k+1, and `bus_req` is low from N+k+1.
- **Fastest access:** k=1 keeps `mem_wait` high for exactly 1 cycle.
- **Timeout:** with no ack, `mem_wait` goes low in cycle N+TIMEOUT, `bus_req` drops at N+TIMEOUT+1, and `bus_err` is visible from N+TIMEOUT+1.
- **Misaligned access:** `mem_wait` is high in N only, and `align_err` is visible from N+1.
- **Control-unit behaviour:** it moves MEM→MEM_DELAY→REG_WR, so `mem_rdata` is stable at least 1 cycle before REG_WR.

## Test plan
- **Word load, ack after 3 cycles:** addr=0x0010, bus_rdata=0xBEEF. Expect `bus_addr`=0x0008, `bus_be`=11, `mem_wait` high for N..N+2 and low at N+3, `mem_rdata`=0xBEEF from N+4, exactly one `bus_req` burst.
- **Byte store to 0x0021, wdata=0x12A5:** expect `bus_we`=1, `bus_be`=10, `bus_wdata`=0xA5A5, `bus_addr`=0x0010. Follow with a byte load from 0x0021 with bus_rdata=0x7F00: expect `mem_rdata`=0x007F.
- **Timeout, TIMEOUT=4, no ack:** expect `mem_wait` low at N+4, `bus_err`=1 from N+5, `mem_rdata`=0. A following normal access must still complete and `bus_err` must stay 1.
- **Misaligned word store at 0x0003:** expect no `bus_req`, `align_err`=1, `mem_wait` high for 1 cycle, state DONE.
- **`mem_en` held high 5 cycles after completion:** expect a single bus transaction. Then pulse `rst` while in REQ: expect `bus_req`=0 the next cycle and both flags 0.
- **`en`=0 for 3 cycles during REQ:** expect the bus outputs held, the counter frozen, and the ack accepted after `en` returns high.
